// File: rtl/instr_mem_loader.sv
// Boot-time instruction-memory loader.
// Takes a byte stream made of a 16-bit word-count header followed by words sent MSB-first.
// Assembles 32-bit instructions and writes each one through the instruction-memory write port.
// Every output is a flop. The state-decoded outputs are loaded from the next state, so they
// line up with the state register.
module instr_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W+1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  // Largest legal header count, sized one bit wider than the 16-bit count so that
  // DEPTH = 2**ADDR_W is representable.
  localparam logic [16:0] DEPTH_C = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_COLLECT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [ADDR_W:0]     wl_q, wl_d;
  logic [ADDR_W+1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                hs;
  logic [15:0]         hdr_full;

  assign hs       = in_valid && in_ready_q;
  assign hdr_full = {count_q[15:8], in_data};

  // State register plus all datapath and output flops; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      bcnt_q      <= '0;
      word_q      <= '0;
      wl_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      bcnt_q      <= bcnt_d;
      word_q      <= word_d;
      wl_q        <= wl_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Next-state logic, header/word assembly and the write-port load.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    bcnt_d      = bcnt_q;
    word_d      = word_q;
    wl_d        = wl_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          count_d = '0;
          bcnt_d  = '0;
          word_d  = '0;
          wl_d    = '0;
          state_d = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (hs) begin
          count_d[15:8] = in_data;
          state_d       = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (hs) begin
          count_d[7:0] = in_data;
          if (hdr_full == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, hdr_full} > DEPTH_C) begin
            state_d = S_ERR;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (hs) begin
          word_d = {word_q[DATA_W-9:0], in_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            // The address and data for the write port are latched here,
            // so they stay valid through WRITE and hold their values afterwards.
            mem_addr_d  = {wl_q[ADDR_W-1:0], 2'b00};
            mem_wdata_d = word_d;
            state_d     = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // words_loaded doubles as the word index. It is one bit wider than the
        // address, so a full-depth image ends at DEPTH rather than wrapping to 0.
        wl_d    = wl_q + 1'b1;
        state_d = (16'(wl_d) == count_q) ? S_DONE : S_COLLECT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the next state, so the flops match the state register.
  always_comb begin
    in_ready_d = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    error_d    = 1'b0;
    mem_we_d   = 1'b0;
    unique case (state_d)
      S_IDLE:                        busy_d     = 1'b0;
      S_HDR_HI, S_HDR_LO, S_COLLECT: in_ready_d = 1'b1;
      S_WRITE:                       mem_we_d   = 1'b1;
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      S_ERR: begin
        busy_d  = 1'b0;
        error_d = 1'b1;
      end
      default:                       busy_d     = 1'b0;
    endcase
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader.
// Inputs change on the falling edge, and outputs are sampled 1 ns after the rising edge.
module tb_instr_mem_loader;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W+1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int tests = 0;
  int fails = 0;

  // Write-port and handshake monitor.
  int          nw = 0;
  int          hs_total = 0;
  logic [9:0]  wr_addr [0:1023];
  logic [31:0] wr_data [0:1023];
  int          wr_hs   [0:1023];
  logic [31:0] tb_mem  [0:255];

  instr_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) hs_total++;
    if (rst_n && mem_we) begin
      if (nw < 1024) begin
        wr_addr[nw] = mem_addr;
        wr_data[nw] = mem_wdata;
        wr_hs[nw]   = hs_total;
      end
      tb_mem[mem_addr[9:2]] = mem_wdata;
      nw++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte and return 1 ns after the edge that consumed it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_byte_timeout: in_ready got 0 expected 1 (byte %h)", b);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_byte_gap(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) @(negedge clk);
    send_byte(b);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({in_ready, mem_we, busy, done, error} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 00000", {in_ready, mem_we, busy, done, error});
    end
    tests++;
    if (mem_addr !== '0 || mem_wdata !== '0 || words_loaded !== '0) begin
      fails++;
      $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", mem_addr, mem_wdata, words_loaded);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Stream part of an image, then pull reset asynchronously mid-word.
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'h11223344);
    send_byte(8'h55); send_byte(8'h66);
    tests++;
    if (busy !== 1'b1 || mem_wdata !== 32'h11223344) begin
      fails++;
      $display("FAIL pre_reset_state: got busy=%b wdata=%h expected 1/11223344", busy, mem_wdata);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, mem_we, busy, done, error} !== 5'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || words_loaded !== '0) begin
      fails++;
      $display("FAIL async_reset: got rdy=%b we=%b busy=%b wdata=%h wl=%0d expected all 0",
               in_ready, mem_we, busy, mem_wdata, words_loaded);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got rdy=%b busy=%b done=%b expected 0/0/0", in_ready, busy, done);
    end
  endtask

  task automatic test_two_words();
    int w0;
    w0 = nw;
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'h20080005);
    send_byte(8'h8C); send_byte(8'h09); send_byte(8'h00); send_byte(8'h04);
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== 10'h004 || mem_wdata !== 32'h8C090004 || done !== 1'b0) begin
      fails++;
      $display("FAIL write1_timing: got we=%b addr=%h data=%h done=%b expected 1/004/8C090004/0",
               mem_we, mem_addr, mem_wdata, done);
    end
    @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0 || words_loaded !== 9'd2) begin
      fails++;
      $display("FAIL two_words_done: got done=%b busy=%b we=%b wl=%0d expected 1/0/0/2",
               done, busy, mem_we, words_loaded);
    end
    tests++;
    if (nw - w0 !== 2 || wr_addr[w0] !== 10'h000 || wr_data[w0] !== 32'h20080005 ||
        wr_addr[w0+1] !== 10'h004 || wr_data[w0+1] !== 32'h8C090004) begin
      fails++;
      $display("FAIL two_words_writes: got n=%0d %h@%h %h@%h expected 2 20080005@000 8C090004@004",
               nw - w0, wr_data[w0], wr_addr[w0], wr_data[w0+1], wr_addr[w0+1]);
    end
    tests++;
    if (mem_addr !== 10'h004 || mem_wdata !== 32'h8C090004) begin
      fails++;
      $display("FAIL hold_after_write: got %h/%h expected 004/8C090004", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_empty_image();
    int w0;
    w0 = nw;
    pulse_start();
    tests++;
    if (done !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL start_clears_done: got done=%b busy=%b rdy=%b expected 0/1/1", done, busy, in_ready);
    end
    send_byte(8'h00); send_byte(8'h00);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || words_loaded !== 9'd0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL empty_done: got done=%b busy=%b wl=%0d rdy=%b expected 1/0/0/0",
               done, busy, words_loaded, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (nw !== w0) begin
      fails++;
      $display("FAIL empty_no_write: got %0d writes expected 0", nw - w0);
    end
  endtask

  task automatic test_header_error();
    int w0;
    w0 = nw;
    pulse_start();
    send_byte(8'h01); send_byte(8'h01);
    tests++;
    if (error !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL header_error: got err=%b rdy=%b done=%b busy=%b expected 1/0/0/0",
               error, in_ready, done, busy);
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hAB;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (nw !== w0 || error !== 1'b1) begin
      fails++;
      $display("FAIL error_no_write: got writes=%0d err=%b expected 0/1", nw - w0, error);
    end
    pulse_start();
    tests++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_clears_error: got err=%b busy=%b expected 0/1", error, busy);
    end
    send_byte(8'h00); send_byte(8'h01);
    send_word(32'hDEADBEEF);
    @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b1 || nw - w0 !== 1 || wr_addr[w0] !== 10'h000 || wr_data[w0] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL reload_after_error: got done=%b n=%0d %h@%h expected 1/1 DEADBEEF@000",
               done, nw - w0, wr_data[w0], wr_addr[w0]);
    end
  endtask

  task automatic test_gaps();
    int w0;
    int h0;
    w0 = nw;
    pulse_start();
    send_byte(8'h00); send_byte(8'h03);
    h0 = hs_total;
    for (int i = 1; i <= 12; i++) begin
      send_byte_gap(8'(i), int'($urandom_range(0, 3)));
      if (i == 6) begin
        pulse_start();
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          fails++;
          $display("FAIL start_while_busy: got busy=%b done=%b expected 1/0", busy, done);
        end
      end
    end
    @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b1 || words_loaded !== 9'd3 || nw - w0 !== 3) begin
      fails++;
      $display("FAIL gaps_done: got done=%b wl=%0d writes=%0d expected 1/3/3", done, words_loaded, nw - w0);
    end
    tests++;
    if (wr_data[w0] !== 32'h01020304 || wr_data[w0+1] !== 32'h05060708 || wr_data[w0+2] !== 32'h090A0B0C ||
        wr_addr[w0+2] !== 10'h008) begin
      fails++;
      $display("FAIL gaps_order: got %h %h %h@%h expected 01020304 05060708 090A0B0C@008",
               wr_data[w0], wr_data[w0+1], wr_data[w0+2], wr_addr[w0+2]);
    end
    tests++;
    if (wr_hs[w0] - h0 !== 4 || wr_hs[w0+1] - wr_hs[w0] !== 4 || wr_hs[w0+2] - wr_hs[w0+1] !== 4) begin
      fails++;
      $display("FAIL handshakes_per_write: got %0d %0d %0d expected 4 4 4",
               wr_hs[w0] - h0, wr_hs[w0+1] - wr_hs[w0], wr_hs[w0+2] - wr_hs[w0+1]);
    end
  endtask

  task automatic test_reset_mid_word();
    int w0;
    w0 = nw;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_word(32'hAABBCCDD);
    @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b1 || nw - w0 !== 1 || wr_addr[w0] !== 10'h000 || wr_data[w0] !== 32'hAABBCCDD) begin
      fails++;
      $display("FAIL reset_mid_word: got done=%b n=%0d %h@%h expected 1/1 AABBCCDD@000",
               done, nw - w0, wr_data[w0], wr_addr[w0]);
    end
  endtask

  task automatic test_full_depth();
    int w0;
    int bad;
    w0 = nw;
    bad = 0;
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_word(32'hC0DE0000 | 32'(i));
    @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 9'd256 || nw - w0 !== 256) begin
      fails++;
      $display("FAIL full_depth_done: got done=%b err=%b wl=%0d writes=%0d expected 1/0/256/256",
               done, error, words_loaded, nw - w0);
    end
    tests++;
    if (wr_addr[w0+255] !== 10'h3FC || mem_addr !== 10'h3FC) begin
      fails++;
      $display("FAIL full_depth_last_addr: got %h/%h expected 3FC", wr_addr[w0+255], mem_addr);
    end
    for (int i = 0; i < 256; i++) if (tb_mem[i] !== (32'hC0DE0000 | 32'(i))) bad++;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL full_depth_contents: got %0d bad words expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_empty_image();
    test_header_error();
    test_gaps();
    test_reset_mid_word();
    test_full_depth();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
